// File: rtl/phy_lane_sched.sv
// phy_lane_sched: round-robin scheduler merging two buffered byte lanes onto one slotted PHY stream.
module phy_lane_sched #(
  parameter int DEPTH = 4,
  parameter int SLOT_CYCLES = 2,
  parameter int TRAIN_WORDS = 4,
  parameter logic [7:0] COMMA = 8'hBC
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic [7:0] data_in_0,
  input  logic       valid_in_0,
  output logic       ready_0,
  input  logic [7:0] data_in_1,
  input  logic       valid_in_1,
  output logic       ready_1,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       lane_out,
  output logic       sync_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
  localparam int TW = TRAIN_WORDS > 1 ? $clog2(TRAIN_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, TRAIN, RUN} state_t;
  state_t state, state_nx;
  logic [SW-1:0] slot_cnt;
  logic [TW-1:0] train_cnt;
  logic last_lane;
  logic [7:0] mem [2][DEPTH];
  logic [7:0] din [2];
  logic [AW-1:0] wp [2], rp [2];
  logic [AW:0] cnt [2], cnt_nx [2];
  logic [1:0] push, pop, ne;
  logic strobe, sched, sel, any;
  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign strobe = slot_cnt == SW'(SLOT_CYCLES - 1);
  assign sched = state == RUN && strobe && enable;
  assign ne = {cnt[1] != '0, cnt[0] != '0};
  assign any = |ne;
  // Prefer the lane not served last; fall back to the other one.
  assign sel = ne[!last_lane] ? !last_lane : last_lane;
  assign push = {valid_in_1, valid_in_0} & {ready_1, ready_0};
  assign pop = (sched && any) ? (2'b01 << sel) : 2'b00;
  always_comb begin
    state_nx = !enable ? IDLE :
               state == IDLE ? TRAIN :
               (state == TRAIN && strobe && train_cnt == TW'(TRAIN_WORDS - 1)) ? RUN : state;
    for (int k = 0; k < 2; k++)
      cnt_nx[k] = enable ? cnt[k] + (AW+1)'(push[k]) - (AW+1)'(pop[k]) : '0;
  end
  always_ff @(posedge clk_8f) begin
    for (int k = 0; k < 2; k++)
      if (push[k]) mem[k][wp[k]] <= din[k];
  end
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
      slot_cnt <= '0;
      train_cnt <= '0;
      last_lane <= 1'b1;
      data_out <= COMMA;
      valid_out <= 1'b0;
      lane_out <= 1'b0;
      sync_done <= 1'b0;
      ready_0 <= 1'b0;
      ready_1 <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        wp[k] <= '0;
        rp[k] <= '0;
        cnt[k] <= '0;
      end
    end else begin
      state <= state_nx;
      slot_cnt <= (!enable || strobe) ? '0 : slot_cnt + 1'b1;
      train_cnt <= !enable ? '0 : (state == TRAIN && strobe) ? train_cnt + 1'b1 : train_cnt;
      sync_done <= state_nx == RUN;
      // Registered from next count so a full FIFO never sees ready high.
      ready_0 <= enable && cnt_nx[0] < (AW+1)'(DEPTH);
      ready_1 <= enable && cnt_nx[1] < (AW+1)'(DEPTH);
      for (int k = 0; k < 2; k++) begin
        cnt[k] <= cnt_nx[k];
        wp[k] <= !enable ? '0 : wp[k] + AW'(push[k]);
        rp[k] <= !enable ? '0 : rp[k] + AW'(pop[k]);
      end
      if (!enable) begin
        data_out <= COMMA;
        valid_out <= 1'b0;
        lane_out <= 1'b0;
        last_lane <= 1'b1;
      end else if (sched) begin
        data_out <= any ? mem[sel][rp[sel]] : COMMA;
        valid_out <= any;
        lane_out <= any & sel;
        last_lane <= any ? sel : last_lane;
      end else if (state == TRAIN && strobe) begin
        data_out <= COMMA;
        valid_out <= 1'b0;
        lane_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_phy_lane_sched.sv
// tb_phy_lane_sched: scoreboard bench for the two-lane PHY scheduler (DEPTH=4, SLOT_CYCLES=2, TRAIN_WORDS=4).
module tb_phy_lane_sched;
  localparam int SC = 2;
  logic clk_8f = 1'b0, reset_L = 1'b0, enable = 1'b0;
  logic [7:0] data_in_0 = '0, data_in_1 = '0;
  logic valid_in_0 = 1'b0, valid_in_1 = 1'b0;
  logic ready_0, ready_1, valid_out, lane_out, sync_done;
  logic [7:0] data_out;
  int n_chk = 0, n_fail = 0, n_out = 0, ph = 0, base;
  logic sync_q = 1'b0;
  logic [8:0] exp_q [$];
  logic [8:0] exp_h;

  phy_lane_sched dut (
    .clk_8f(clk_8f), .reset_L(reset_L), .enable(enable),
    .data_in_0(data_in_0), .valid_in_0(valid_in_0), .ready_0(ready_0),
    .data_in_1(data_in_1), .valid_in_1(valid_in_1), .ready_1(ready_1),
    .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out), .sync_done(sync_done)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_8f);
    #1;
  endtask

  task automatic send(input bit lane, input logic [7:0] b);
    bit r = 1'b0;
    if (lane) begin valid_in_1 = 1'b1; data_in_1 = b; end
    else begin valid_in_0 = 1'b1; data_in_0 = b; end
    for (int i = 0; i < 60 && !r; i++) begin
      @(negedge clk_8f);
      r = lane ? ready_1 : ready_0;
      @(posedge clk_8f);
    end
    if (!r) chk("send_timeout", r, 1);
    #1;
    if (lane) valid_in_1 = 1'b0; else valid_in_0 = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk_8f);
    chk(tag, exp_q.size(), 0);
    repeat (4) @(posedge clk_8f);
    #1;
  endtask

  task automatic train_seq(input string tag);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk_8f);
      @(negedge clk_8f);
      chk(tag, sync_done, e >= 8);
      if (e == 1) chk("ready_after_en", {ready_1, ready_0}, 2'b11);
    end
  endtask

  // Slot-aligned monitor: in RUN every SC-th negedge follows a scheduling strobe.
  always @(negedge clk_8f) begin
    if (!reset_L) sync_q <= 1'b0;
    else if (!sync_done) begin
      sync_q <= 1'b0;
      chk("idle_comma", {valid_out, data_out}, {1'b0, 8'hBC});
    end else begin
      sync_q <= 1'b1;
      ph <= sync_q ? ph + 1 : 0;
      if (!sync_q || (ph + 1) % SC == 0) begin
        if (valid_out && exp_q.size() == 0) chk("unexpected_out", exp_q.size(), 1);
        else if (valid_out) begin
          exp_h = exp_q.pop_front();
          chk("out_data", data_out, exp_h[7:0]);
          chk("out_lane", lane_out, exp_h[8]);
          n_out <= n_out + 1;
        end else chk("slot_comma", {lane_out, valid_out, data_out}, {2'b00, 8'hBC});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (4) @(posedge clk_8f);
    #1;
    chk("rst_out", {sync_done, ready_1, ready_0, lane_out, valid_out, data_out}, {5'b0, 8'hBC});
    reset_L = 1'b1;
    enable = 1'b1;
    train_seq("sync_edge");
    step();
    // Both lanes pushed in lockstep: strict alternation starting with lane 0.
    exp_q.push_back({1'b0, 8'hDD}); exp_q.push_back({1'b1, 8'hCC});
    exp_q.push_back({1'b0, 8'hEE}); exp_q.push_back({1'b1, 8'hBB});
    exp_q.push_back({1'b0, 8'hFF}); exp_q.push_back({1'b1, 8'hAA});
    fork
      begin send(0, 8'hDD); send(0, 8'hEE); send(0, 8'hFF); end
      begin send(1, 8'hCC); send(1, 8'hBB); send(1, 8'hAA); end
    join
    drain("drain_ilv");
    exp_q.push_back({1'b1, 8'h11}); exp_q.push_back({1'b1, 8'h22}); exp_q.push_back({1'b1, 8'h33});
    send(1, 8'h11); send(1, 8'h22); send(1, 8'h33);
    drain("drain_single");
    exp_q.push_back({1'b0, 8'hDD}); exp_q.push_back({1'b1, 8'h44});
    fork
      send(0, 8'hDD);
      send(1, 8'h44);
    join
    drain("drain_starve");
    // Backpressure: fill lane 0 during training, when nothing is popped.
    enable = 1'b0;
    step();
    chk("idle_ready", {sync_done, ready_1, ready_0}, 3'b000);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, 8'h60 + 8'(i)});
      send(0, 8'h60 + 8'(i));
    end
    @(negedge clk_8f);
    chk("full_ready0", ready_0, 0);
    chk("full_ready1", ready_1, 1);
    chk("full_in_train", sync_done, 0);
    exp_q.push_back({1'b0, 8'h64});
    send(0, 8'h64);
    drain("drain_bp");
    // Enable drop with two bytes still queued.
    enable = 1'b0;
    step();
    enable = 1'b1;
    base = n_out;
    exp_q.push_back({1'b0, 8'hA0}); exp_q.push_back({1'b1, 8'hB0});
    exp_q.push_back({1'b0, 8'hA1}); exp_q.push_back({1'b1, 8'hB1});
    fork
      begin send(0, 8'hA0); send(0, 8'hA1); end
      begin send(1, 8'hB0); send(1, 8'hB1); end
    join
    for (int i = 0; i < 100 && n_out < base + 2; i++) step();
    chk("two_out", n_out, base + 2);
    enable = 1'b0;
    exp_q.delete();
    step();
    chk("drop_out", {sync_done, ready_1, ready_0, lane_out, valid_out, data_out}, {5'b0, 8'hBC});
    enable = 1'b1;
    train_seq("resync_edge");
    repeat (10) @(posedge clk_8f);
    #1;
    // Async reset between edges while a valid byte is on the output.
    base = n_out;
    exp_q.push_back({1'b1, 8'h5A});
    send(1, 8'h5A);
    for (int i = 0; i < 100 && n_out < base + 1; i++) step();
    #2;
    chk("pre_rst_valid", {valid_out, lane_out, data_out}, {2'b11, 8'h5A});
    reset_L = 1'b0;
    #1;
    chk("async_rst", {sync_done, ready_1, ready_0, lane_out, valid_out, data_out}, {5'b0, 8'hBC});
    repeat (3) @(posedge clk_8f);
    chk("final_q", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
